// File: rtl/updown_counter_core.sv
// Decimal up/down counter (0..MAX_COUNT) with a STOP/RUN/CLEAR control FSM and a tick prescaler.
// Define BTN_EDGE_DET_EN to treat the request inputs as async levels (sync + rising-edge detect).
module updown_counter_core #(
   parameter int TICK_DIV  = 10_000_000,
   parameter int MAX_COUNT = 9999,
   parameter int CNT_W     = 14
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_run_stop,
   input  logic             i_clear,
   input  logic             i_mode,
   output logic [CNT_W-1:0] o_count,
   output logic             o_mode,
   output logic             o_run,
   output logic             o_tick
);

   localparam int               PRE_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_COUNT);

   typedef enum logic [1:0] {
      STOP  = 2'd0,
      RUN   = 2'd1,
      CLEAR = 2'd2
   } state_t;

   state_t           state;
   logic [PRE_W-1:0] prescaler;
   logic             req_run_stop;
   logic             req_clear;
   logic             req_mode;

`ifdef BTN_EDGE_DET_EN
   logic [2:0] sync1;
   logic [2:0] sync2;
   logic [2:0] prev;

   // Two-stage synchronizer, then a one-cycle request on each rising edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
      end else begin
         sync1 <= {i_run_stop, i_clear, i_mode};
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign {req_run_stop, req_clear, req_mode} = sync2 & ~prev;
`else
   assign req_run_stop = i_run_stop;
   assign req_clear    = i_clear;
   assign req_mode     = i_mode;
`endif

   function automatic logic [CNT_W-1:0] step(input logic [CNT_W-1:0] cur, input logic down);
      logic [CNT_W-1:0] nxt;
      if (down) nxt = (cur == '0) ? CNT_MAX : cur - CNT_W'(1);
      else      nxt = (cur == CNT_MAX) ? '0 : cur + CNT_W'(1);
      return nxt;
   endfunction

   // Clear beats run in STOP; a tick landing with run_stop still updates before stopping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= STOP;
         prescaler <= '0;
         o_count   <= '0;
         o_mode    <= 1'b0;
         o_run     <= 1'b0;
         o_tick    <= 1'b0;
      end else begin
         o_tick <= 1'b0;
         if (req_mode) o_mode <= ~o_mode;
         case (state)
            STOP: begin
               if (req_clear) begin
                  state <= CLEAR;
                  o_run <= 1'b0;
               end else if (req_run_stop) begin
                  state <= RUN;
                  o_run <= 1'b1;
               end
            end
            RUN: begin
               if (prescaler == PRE_LAST) begin
                  prescaler <= '0;
                  o_count   <= step(o_count, o_mode);
                  o_tick    <= 1'b1;
               end else begin
                  prescaler <= prescaler + PRE_W'(1);
               end
               if (req_run_stop) begin
                  state <= STOP;
                  o_run <= 1'b0;
               end
            end
            CLEAR: begin
               o_count   <= '0;
               prescaler <= '0;
               state     <= STOP;
               o_run     <= 1'b0;
            end
            default: begin
               state <= STOP;
               o_run <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_updown_counter_core.sv
// Directed bench for updown_counter_core at TICK_DIV=4; inputs driven and outputs sampled on negedges.
// With BTN_EDGE_DET_EN defined only the reset and held-level edge-detect scenarios run.
module tb_updown_counter_core;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        i_run_stop = 1'b0;
   logic        i_clear = 1'b0;
   logic        i_mode = 1'b0;
   logic [13:0] o_count;
   logic        o_mode;
   logic        o_run;
   logic        o_tick;

   int checks = 0;
   int errors = 0;

   updown_counter_core #(
      .TICK_DIV (4),
      .MAX_COUNT(9999),
      .CNT_W    (14)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .i_run_stop(i_run_stop),
      .i_clear   (i_clear),
      .i_mode    (i_mode),
      .o_count   (o_count),
      .o_mode    (o_mode),
      .o_run     (o_run),
      .o_tick    (o_tick)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
   endtask

   // One-cycle request pulse; returns on the negedge after the sampling posedge.
   task automatic pulse(input logic rs, input logic clr, input logic md);
      @(negedge clk);
      i_run_stop = rs;
      i_clear    = clr;
      i_mode     = md;
      @(negedge clk);
      i_run_stop = 1'b0;
      i_clear    = 1'b0;
      i_mode     = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (o_count !== 14'd0) begin errors++; $display("[TB] FAIL reset_count got %0d exp 0", o_count); end
      checks++; if (o_mode !== 1'b0) begin errors++; $display("[TB] FAIL reset_mode got %b exp 0", o_mode); end
      checks++; if (o_run !== 1'b0) begin errors++; $display("[TB] FAIL reset_run got %b exp 0", o_run); end
      checks++; if (o_tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick got %b exp 0", o_tick); end
   endtask

   task automatic test_run();
      int ticks = 0;
      int last = -1;
      do_reset();
      pulse(1'b1, 1'b0, 1'b0);
      checks++; if (o_run !== 1'b1) begin errors++; $display("[TB] FAIL run_enter got %b exp 1", o_run); end
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (o_tick === 1'b1) begin
            ticks++;
            if (last >= 0) begin
               checks++;
               if (i - last != 4) begin errors++; $display("[TB] FAIL tick_spacing got %0d exp 4", i - last); end
            end
            last = i;
         end
      end
      checks++; if (ticks != 10) begin errors++; $display("[TB] FAIL tick_total got %0d exp 10", ticks); end
      checks++; if (o_count !== 14'd10) begin errors++; $display("[TB] FAIL run_count got %0d exp 10", o_count); end
      pulse(1'b1, 1'b0, 1'b0);
      checks++; if (o_run !== 1'b0) begin errors++; $display("[TB] FAIL run_stop got %b exp 0", o_run); end
      repeat (8) @(negedge clk);
      checks++; if (o_count !== 14'd10) begin errors++; $display("[TB] FAIL stop_hold got %0d exp 10", o_count); end
   endtask

   task automatic test_wrap();
      bit found = 1'b0;
      do_reset();
      pulse(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 45000 && !found; i++) begin
         @(negedge clk);
         if (o_count === 14'd9999) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++; $display("[TB] FAIL reach_9999 got %0d exp 9999", o_count);
      end else begin
         repeat (4) @(negedge clk);
         checks++; if (o_count !== 14'd0) begin errors++; $display("[TB] FAIL wrap_up got %0d exp 0", o_count); end
         checks++; if (o_tick !== 1'b1) begin errors++; $display("[TB] FAIL wrap_tick got %b exp 1", o_tick); end
         pulse(1'b0, 1'b0, 1'b1);
         checks++; if (o_mode !== 1'b1) begin errors++; $display("[TB] FAIL mode_toggle got %b exp 1", o_mode); end
         repeat (2) @(negedge clk);
         checks++; if (o_count !== 14'd9999) begin errors++; $display("[TB] FAIL wrap_down got %0d exp 9999", o_count); end
      end
   endtask

   task automatic test_clear_in_run();
      do_reset();
      pulse(1'b1, 1'b0, 1'b0);
      repeat (100) @(negedge clk);
      checks++; if (o_count !== 14'd25) begin errors++; $display("[TB] FAIL count_25 got %0d exp 25", o_count); end
      pulse(1'b0, 1'b1, 1'b0);
      checks++; if (o_run !== 1'b1) begin errors++; $display("[TB] FAIL clear_ignored_run got %b exp 1", o_run); end
      repeat (2) @(negedge clk);
      checks++; if (o_count !== 14'd26) begin errors++; $display("[TB] FAIL clear_ignored_count got %0d exp 26", o_count); end
      pulse(1'b1, 1'b0, 1'b0);
      checks++; if (o_run !== 1'b0) begin errors++; $display("[TB] FAIL stop_before_clear got %b exp 0", o_run); end
      pulse(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      checks++; if (o_count !== 14'd0) begin errors++; $display("[TB] FAIL clear_count got %0d exp 0", o_count); end
      checks++; if (o_run !== 1'b0) begin errors++; $display("[TB] FAIL clear_run got %b exp 0", o_run); end
      pulse(1'b1, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      checks++; if (o_count !== 14'd0) begin errors++; $display("[TB] FAIL phase_early got %0d exp 0", o_count); end
      @(negedge clk);
      checks++; if (o_count !== 14'd1) begin errors++; $display("[TB] FAIL phase_first_tick got %0d exp 1", o_count); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      pulse(1'b1, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      checks++; if (o_count !== 14'd1) begin errors++; $display("[TB] FAIL b2b_first got %0d exp 1", o_count); end
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b1, 1'b1, 1'b0);
      checks++; if (o_run !== 1'b0) begin errors++; $display("[TB] FAIL clear_wins_run got %b exp 0", o_run); end
      @(negedge clk);
      checks++; if (o_count !== 14'd0) begin errors++; $display("[TB] FAIL clear_wins_count got %0d exp 0", o_count); end
      pulse(1'b1, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      pulse(1'b0, 1'b0, 1'b1);
      checks++; if (o_count !== 14'd1) begin errors++; $display("[TB] FAIL mode_old_dir got %0d exp 1", o_count); end
      checks++; if (o_mode !== 1'b1) begin errors++; $display("[TB] FAIL mode_on_tick got %b exp 1", o_mode); end
      repeat (4) @(negedge clk);
      checks++; if (o_count !== 14'd0) begin errors++; $display("[TB] FAIL mode_new_dir got %0d exp 0", o_count); end
   endtask

   task automatic test_async_reset();
      do_reset();
      pulse(1'b0, 1'b0, 1'b1);
      pulse(1'b1, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      checks++; if (o_count !== 14'd9999) begin errors++; $display("[TB] FAIL down_from_0 got %0d exp 9999", o_count); end
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checks++; if (o_count !== 14'd0) begin errors++; $display("[TB] FAIL async_count got %0d exp 0", o_count); end
      checks++; if (o_mode !== 1'b0) begin errors++; $display("[TB] FAIL async_mode got %b exp 0", o_mode); end
      checks++; if (o_run !== 1'b0) begin errors++; $display("[TB] FAIL async_run got %b exp 0", o_run); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_edge_detect();
      do_reset();
      @(negedge clk);
      i_run_stop = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (o_run !== 1'b0) begin errors++; $display("[TB] FAIL edge_early got %b exp 0", o_run); end
      @(negedge clk);
      checks++; if (o_run !== 1'b1) begin errors++; $display("[TB] FAIL edge_enter got %b exp 1", o_run); end
      repeat (17) @(negedge clk);
      i_run_stop = 1'b0;
      checks++; if (o_run !== 1'b1) begin errors++; $display("[TB] FAIL edge_held got %b exp 1", o_run); end
      repeat (8) @(negedge clk);
      checks++; if (o_run !== 1'b1) begin errors++; $display("[TB] FAIL edge_release got %b exp 1", o_run); end
   endtask

   initial begin
      test_reset();
`ifdef BTN_EDGE_DET_EN
      test_edge_detect();
`else
      test_run();
      test_wrap();
      test_clear_in_run();
      test_back_to_back();
      test_async_reset();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
